instr_sequencer: RTL and testbench

Program sequencer for the 8-bit mini CPU. It holds a 16-word × 4-bit program store and steps through it from address 0. It issues one 4-bit opcode at a time to the instruction decoder over a valid/ready handshake. It sits upstream of the decoder and is the producer of every `Instruction` value the decoder consumes; it supports free-run and single-step execution.

---
 rtl/instr_sequencer.sv | 161 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Program sequencer: 16 x 4-bit program store issuing opcodes to the decoder over valid/ready.
// Supports free-run and single-step execution; opcode 4'b1111 marks end of program.
module instr_sequencer #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Load,
    input  logic [3:0] LoadAddr,
    input  logic [3:0] LoadData,
    input  logic       Start,
    input  logic       Abort,
    input  logic       StepMode,
    input  logic       Step,
    input  logic       Ready,
    output logic [3:0] Instruction,
    output logic       InstrValid,
    output logic [3:0] PC,
    output logic       Busy,
    output logic       Halted
);

    localparam logic [3:0] OpHalt   = 4'b1111;
    localparam logic [3:0] LastAddr = 4'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StHalt
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] instr_q, instr_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       halted_q, halted_d;
    logic [3:0] mem_q [DEPTH];
    logic [3:0] mem_d [DEPTH];

    logic       load_en;
    logic       accept;
    logic [3:0] pc_inc;
    logic [3:0] first_word;
    logic [3:0] next_word;
    logic [3:0] cur_word;

    // The store is only writable while nothing is executing.
    always_comb begin
        load_en = Load && ((state_q == StIdle) || (state_q == StHalt));
        mem_d   = mem_q;
        if (load_en) begin
            mem_d[LoadAddr] = LoadData;
        end
    end

    always_comb begin
        accept     = valid_q && Ready;
        pc_inc     = pc_q + 4'd1;
        // Start sees a same-cycle write to address 0.
        first_word = mem_d[0];
        next_word  = mem_q[pc_inc];
        cur_word   = mem_q[pc_q];
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;

        if (Abort) begin
            state_d = StIdle;
            pc_d    = 4'd0;
            instr_d = OpHalt;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle, StHalt: begin
                    if (Start) begin
                        pc_d = 4'd0;
                        if (first_word == OpHalt) begin
                            state_d = StHalt;
                            instr_d = OpHalt;
                            valid_d = 1'b0;
                        end else begin
                            state_d = StRun;
                            instr_d = first_word;
                            valid_d = 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (accept) begin
                        instr_d = OpHalt;
                        valid_d = 1'b0;
                        if (pc_q == LastAddr) begin
                            state_d = StHalt;
                        end else begin
                            pc_d = pc_inc;
                            if (next_word == OpHalt) begin
                                state_d = StHalt;
                            end else if (StepMode) begin
                                state_d = StPause;
                            end else begin
                                instr_d = next_word;
                                valid_d = 1'b1;
                            end
                        end
                    end
                end
                StPause: begin
                    if (Step) begin
                        state_d = StRun;
                        instr_d = cur_word;
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    pc_d    = 4'd0;
                    instr_d = OpHalt;
                    valid_d = 1'b0;
                end
            endcase
        end

        busy_d   = (state_d == StRun) || (state_d == StPause);
        halted_d = (state_d == StHalt);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= StIdle;
            pc_q     <= 4'd0;
            instr_q  <= OpHalt;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= OpHalt;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            mem_q    <= mem_d;
        end
    end

    assign Instruction = instr_q;
    assign InstrValid  = valid_q;
    assign PC          = pc_q;
    assign Busy        = busy_q;
    assign Halted      = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the program store and execution mode.
module tb_instr_sequencer;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] load_addr;
    logic [3:0] load_data;
    logic       start;
    logic       abort;
    logic       step_mode;
    logic       step;
    logic       ready;
    logic [3:0] instruction;
    logic       instr_valid;
    logic [3:0] pc;
    logic       busy;
    logic       halted;

    int n_checks;
    int n_fail;

    instr_sequencer #(
        .DEPTH(16)
    ) dut (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .Load       (load),
        .LoadAddr   (load_addr),
        .LoadData   (load_data),
        .Start      (start),
        .Abort      (abort),
        .StepMode   (step_mode),
        .Step       (step),
        .Ready      (ready),
        .Instruction(instruction),
        .InstrValid (instr_valid),
        .PC         (pc),
        .Busy       (busy),
        .Halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: execution mode, program counter and the program itself.
    localparam int MIdle  = 0;
    localparam int MRun   = 1;
    localparam int MPause = 2;
    localparam int MHalt  = 3;

    int         m_mode;
    int         m_pc;
    logic [3:0] m_mem [16];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = MIdle;
        m_pc   = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 4'hF;
    endtask

    task automatic model_edge();
        if (load && (m_mode == MIdle || m_mode == MHalt)) m_mem[load_addr] = load_data;
        if (abort) begin
            m_mode = MIdle;
            m_pc   = 0;
            return;
        end
        case (m_mode)
            MIdle, MHalt: begin
                if (start) begin
                    m_pc   = 0;
                    m_mode = (m_mem[0] == 4'hF) ? MHalt : MRun;
                end
            end
            MRun: begin
                if (ready) begin
                    if (m_pc == 15) begin
                        m_mode = MHalt;
                    end else begin
                        m_pc = m_pc + 1;
                        if (m_mem[m_pc] == 4'hF) m_mode = MHalt;
                        else if (step_mode) m_mode = MPause;
                    end
                end
            end
            MPause: if (step) m_mode = MRun;
            default: m_mode = MIdle;
        endcase
    endtask

    task automatic compare_outputs();
        logic       e_valid;
        logic [3:0] e_instr;
        e_valid = (m_mode == MRun);
        e_instr = e_valid ? m_mem[m_pc] : 4'hF;
        check("instr", {4'h0, instruction}, {4'h0, e_instr});
        check("valid", {7'h0, instr_valid}, {7'h0, e_valid});
        check("pc", {4'h0, pc}, 8'(m_pc));
        check("busy", {7'h0, busy}, {7'h0, (m_mode == MRun || m_mode == MPause)});
        check("halted", {7'h0, halted}, {7'h0, (m_mode == MHalt)});
    endtask

    // One clock: inputs are already driven; sample on the falling edge.
    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic quiet();
        load  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        step  = 1'b0;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [3:0] d);
        quiet();
        load      = 1'b1;
        load_addr = a;
        load_data = d;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        int cnt;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        load_addr = 4'h0;
        load_data = 4'h0;
        step_mode = 1'b0;
        ready     = 1'b0;
        quiet();
        model_reset();

        // Reset values
        @(negedge clk);
        compare_outputs();
        check("rst_instr", {4'h0, instruction}, 8'h0F);
        @(negedge clk);
        rst_n = 1'b1;

        // Three-word program with HALT at address 3
        load_word(4'd0, 4'b0000);
        load_word(4'd1, 4'b0001);
        load_word(4'd2, 4'b0100);
        ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("t1_w0", {3'h0, instr_valid, instruction}, 8'h10);
        cyc();
        check("t1_w1", {3'h0, instr_valid, instruction}, 8'h11);
        cyc();
        check("t1_w2", {3'h0, instr_valid, instruction}, 8'h14);
        cyc();
        check("t1_halt", {3'h0, halted, pc}, 8'h13);
        check("t1_novalid", {7'h0, instr_valid}, 8'h0);

        // Same program, stalled on the second word
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t2_hold", {pc, instruction}, 8'h11);
        end
        ready = 1'b1;
        cyc();
        check("t2_w2", {3'h0, instr_valid, instruction}, 8'h14);
        cyc();
        check("t2_halt", {3'h0, halted, pc}, 8'h13);

        // Full store, no HALT marker: 16 words then HALT at PC 15 without wrap
        for (int a = 0; a < 16; a++) load_word(4'(a), 4'b1010);
        ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) cnt++;
            cyc();
        end
        check("t3_count", 8'(cnt), 8'd16);
        check("t3_halt", {3'h0, halted, pc}, 8'h1F);

        // Step mode
        load_word(4'd0, 4'b0010);
        load_word(4'd1, 4'b0011);
        load_word(4'd2, 4'b1111);
        step_mode = 1'b1;
        start     = 1'b1;
        cyc();
        start = 1'b0;
        check("t4_w0", {3'h0, instr_valid, instruction}, 8'h12);
        cyc();
        check("t4_pause", {2'h0, busy, instr_valid, pc}, 8'h21);
        cyc();
        check("t4_still", {2'h0, busy, instr_valid, pc}, 8'h21);
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("t4_w1", {3'h0, instr_valid, instruction}, 8'h13);
        cyc();
        check("t4_halt", {3'h0, halted, pc}, 8'h12);
        step_mode = 1'b0;

        // Load during RUN is ignored; Abort discards the presented word
        load_word(4'd2, 4'b1010);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        check("t5_pc2", {4'h0, pc}, 8'h02);
        ready     = 1'b0;
        load      = 1'b1;
        load_addr = 4'd0;
        load_data = 4'b0110;
        cyc();
        load  = 1'b0;
        abort = 1'b1;
        ready = 1'b1;
        cyc();
        abort = 1'b0;
        check("t5_abort", {2'h0, busy, instr_valid, pc}, 8'h00);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("t5_store", {3'h0, instr_valid, instruction}, 8'h12);

        // Asynchronous reset mid-run
        cyc();
        @(posedge clk);
        model_edge();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst", {instr_valid, busy, halted, 1'b0, instruction}, 8'h0F);
        check("t6_pc", {4'h0, pc}, 8'h00);
        @(negedge clk);
        compare_outputs();
        cyc();
        rst_n = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("t6_empty", {3'h0, halted, 3'h0, instr_valid}, 8'h10);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            load      = ($urandom_range(0, 3) == 0);
            load_addr = 4'($urandom_range(0, 15));
            load_data = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
            start     = ($urandom_range(0, 15) == 0);
            abort     = ($urandom_range(0, 60) == 0);
            if (abort) load = 1'b0;
            step_mode = ($urandom_range(0, 3) == 0);
            step      = ($urandom_range(0, 3) == 0);
            ready     = ($urandom_range(0, 9) < 7);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
